// File: rtl/ntt_result_serializer.sv
// ntt_result_serializer
// Captures a 16-lane NTT result block in one cycle and streams the words out
// one per cycle in lane order over a valid/ready port. A new block may be
// chained on the lane-15 handshake so consecutive blocks leave with no gap.
// All outputs except ready_out are registered; ready_out must be
// combinational so a chained load can be accepted on the final handshake.

module ntt_result_serializer #(
    parameter int unsigned        P_WIDTH = 64,
    parameter logic [P_WIDTH-1:0] P_ZERO  = 64'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [P_WIDTH-1:0] Result0_in,
    input  logic [P_WIDTH-1:0] Result1_in,
    input  logic [P_WIDTH-1:0] Result2_in,
    input  logic [P_WIDTH-1:0] Result3_in,
    input  logic [P_WIDTH-1:0] Result4_in,
    input  logic [P_WIDTH-1:0] Result5_in,
    input  logic [P_WIDTH-1:0] Result6_in,
    input  logic [P_WIDTH-1:0] Result7_in,
    input  logic [P_WIDTH-1:0] Result8_in,
    input  logic [P_WIDTH-1:0] Result9_in,
    input  logic [P_WIDTH-1:0] Result10_in,
    input  logic [P_WIDTH-1:0] Result11_in,
    input  logic [P_WIDTH-1:0] Result12_in,
    input  logic [P_WIDTH-1:0] Result13_in,
    input  logic [P_WIDTH-1:0] Result14_in,
    input  logic [P_WIDTH-1:0] Result15_in,
    input  logic               load_in,
    output logic               ready_out,
    output logic [P_WIDTH-1:0] Data_out,
    output logic               valid_out,
    input  logic               ready_in,
    output logic [3:0]         index_out,
    output logic               last_out,
    output logic               done_out
);

    localparam int unsigned LANES    = 16;
    localparam logic [3:0]  LAST_IDX = 4'd15;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // State and storage
    state_t             state_r;
    state_t             state_nxt_s;
    logic [3:0]         idx_r;
    logic [3:0]         idx_nxt_s;
    logic [3:0]         idx_inc_s;
    logic [P_WIDTH-1:0] buf_r   [LANES];
    logic [P_WIDTH-1:0] lanes_s [LANES];

    // Registered outputs and their next values
    logic [P_WIDTH-1:0] data_r;
    logic [P_WIDTH-1:0] data_nxt_s;
    logic [3:0]         index_r;
    logic [3:0]         index_nxt_s;
    logic               last_r;
    logic               last_nxt_s;
    logic               valid_r;
    logic               valid_nxt_s;
    logic               done_r;
    logic               done_nxt_s;

    // Handshake qualifiers
    logic               ready_s;
    logic               load_acc_s;
    logic               hs_s;
    logic               at_last_s;

    // Gather the individual lane ports into an indexable array
    always_comb begin
        lanes_s[0]  = Result0_in;
        lanes_s[1]  = Result1_in;
        lanes_s[2]  = Result2_in;
        lanes_s[3]  = Result3_in;
        lanes_s[4]  = Result4_in;
        lanes_s[5]  = Result5_in;
        lanes_s[6]  = Result6_in;
        lanes_s[7]  = Result7_in;
        lanes_s[8]  = Result8_in;
        lanes_s[9]  = Result9_in;
        lanes_s[10] = Result10_in;
        lanes_s[11] = Result11_in;
        lanes_s[12] = Result12_in;
        lanes_s[13] = Result13_in;
        lanes_s[14] = Result14_in;
        lanes_s[15] = Result15_in;
    end

    // Accept a block when idle, or when the last word is leaving this cycle
    always_comb begin
        at_last_s  = (idx_r == LAST_IDX);
        hs_s       = (state_r == ST_STREAM) && ready_in;
        ready_s    = (state_r == ST_IDLE) || (hs_s && at_last_s);
        load_acc_s = load_in && ready_s;
        idx_inc_s  = idx_r + 4'd1;
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        data_nxt_s  = data_r;
        index_nxt_s = index_r;
        last_nxt_s  = last_r;
        valid_nxt_s = valid_r;
        done_nxt_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (load_in) begin
                    // Lane 0 goes straight to the output register while
                    // the buffer captures the whole block.
                    state_nxt_s = ST_STREAM;
                    idx_nxt_s   = 4'd0;
                    data_nxt_s  = lanes_s[0];
                    index_nxt_s = 4'd0;
                    last_nxt_s  = 1'b0;
                    valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    valid_nxt_s = 1'b0;
                end
            end

            ST_STREAM: begin
                if (hs_s) begin
                    if (!at_last_s) begin
                        idx_nxt_s   = idx_inc_s;
                        data_nxt_s  = buf_r[idx_inc_s];
                        index_nxt_s = idx_inc_s;
                        last_nxt_s  = (idx_inc_s == LAST_IDX);
                        valid_nxt_s = 1'b1;
                    end else begin
                        done_nxt_s = 1'b1;
                        idx_nxt_s  = 4'd0;
                        if (load_in) begin
                            // Chained block: lane 0 follows lane 15 directly.
                            state_nxt_s = ST_STREAM;
                            data_nxt_s  = lanes_s[0];
                            index_nxt_s = 4'd0;
                            last_nxt_s  = 1'b0;
                            valid_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            data_nxt_s  = P_ZERO;
                            index_nxt_s = 4'd0;
                            last_nxt_s  = 1'b0;
                            valid_nxt_s = 1'b0;
                        end
                    end
                end else begin
                    // Stalled: outputs already hold their values.
                    valid_nxt_s = 1'b1;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = 4'd0;
                data_nxt_s  = P_ZERO;
                index_nxt_s = 4'd0;
                last_nxt_s  = 1'b0;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, index and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= 4'd0;
            data_r  <= P_ZERO;
            index_r <= 4'd0;
            last_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            data_r  <= data_nxt_s;
            index_r <= index_nxt_s;
            last_r  <= last_nxt_s;
            valid_r <= valid_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Block buffer: written only when a load is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                buf_r[k] <= P_ZERO;
            end
        end else if (load_acc_s) begin
            for (int k = 0; k < LANES; k++) begin
                buf_r[k] <= lanes_s[k];
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                buf_r[k] <= buf_r[k];
            end
        end
    end

    assign ready_out = ready_s;
    assign Data_out  = data_r;
    assign valid_out = valid_r;
    assign index_out = index_r;
    assign last_out  = last_r;
    assign done_out  = done_r;

endmodule

// File: tb/tb_ntt_result_serializer.sv
// Directed bench for ntt_result_serializer. Inputs change on the falling
// edge; outputs are checked on the falling edge (or 1 ns after an input
// change for the combinational ready_out).

module tb_ntt_result_serializer;

    logic        clk;
    logic        rst_n;
    logic [63:0] res [16];
    logic        load_in;
    logic        ready_in;
    logic        ready_out;
    logic [63:0] Data_out;
    logic        valid_out;
    logic [3:0]  index_out;
    logic        last_out;
    logic        done_out;

    int errors;
    int checks;

    ntt_result_serializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Result0_in (res[0]),
        .Result1_in (res[1]),
        .Result2_in (res[2]),
        .Result3_in (res[3]),
        .Result4_in (res[4]),
        .Result5_in (res[5]),
        .Result6_in (res[6]),
        .Result7_in (res[7]),
        .Result8_in (res[8]),
        .Result9_in (res[9]),
        .Result10_in(res[10]),
        .Result11_in(res[11]),
        .Result12_in(res[12]),
        .Result13_in(res[13]),
        .Result14_in(res[14]),
        .Result15_in(res[15]),
        .load_in    (load_in),
        .ready_out  (ready_out),
        .Data_out   (Data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .index_out  (index_out),
        .last_out   (last_out),
        .done_out   (done_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present a block with lanes base+k and pulse load across one rising edge.
    // Returns at the falling edge where lane 0 should be visible.
    task automatic load_block(input logic [63:0] base);
        for (int k = 0; k < 16; k++) res[k] = base + 64'(k);
        load_in = 1'b1;
        @(negedge clk);
        load_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || done_out !== 1'b0 || Data_out !== 64'h0 ||
            index_out !== 4'd0 || last_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b done=%b data=%h index=%0d last=%b, required 0 0 0 0 0",
                     valid_out, done_out, Data_out, index_out, last_out);
        end
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready_out=%b required 1", ready_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_block();
        logic exp_last;
        ready_in = 1'b1;
        for (int k = 0; k < 16; k++) res[k] = 64'h1000 + 64'(k);
        load_in = 1'b1;
        #1;
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_idle: ready_out=%b required 1", ready_out);
        end
        @(negedge clk);
        load_in = 1'b0;
        for (int w = 0; w < 16; w++) begin
            exp_last = (w == 15) ? 1'b1 : 1'b0;
            checks++;
            if (valid_out !== 1'b1 || Data_out !== 64'h1000 + 64'(w) ||
                index_out !== 4'(w) || last_out !== exp_last || done_out !== 1'b0) begin
                errors++;
                $display("FAIL single_word%0d: valid=%b data=%h index=%0d last=%b done=%b, required 1 %h %0d %b 0",
                         w, valid_out, Data_out, index_out, last_out, done_out,
                         64'h1000 + 64'(w), w, exp_last);
            end
            @(negedge clk);
        end
        checks++;
        if (done_out !== 1'b1 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b valid=%b required 1 0", done_out, valid_out);
        end
        @(negedge clk);
        checks++;
        if (done_out !== 1'b0 || valid_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL single_idle: done=%b valid=%b ready=%b required 0 0 1",
                     done_out, valid_out, ready_out);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        logic       r;
        int         exp;
        int         cyc;
        pat = 4'b1001;
        exp = 0;
        cyc = 0;
        load_block(64'h3000);
        while (exp < 16 && cyc < 200) begin
            checks++;
            if (valid_out !== 1'b1 || Data_out !== 64'h3000 + 64'(exp) ||
                index_out !== 4'(exp) || done_out !== 1'b0) begin
                errors++;
                $display("FAIL bp_word cyc%0d: valid=%b data=%h index=%0d done=%b, required 1 %h %0d 0",
                         cyc, valid_out, Data_out, index_out, done_out, 64'h3000 + 64'(exp), exp);
            end
            r = pat[cyc % 4];
            ready_in = r;
            #1;
            checks++;
            if (ready_out !== ((exp == 15) && r)) begin
                errors++;
                $display("FAIL bp_ready cyc%0d: ready_out=%b required %b",
                         cyc, ready_out, ((exp == 15) && r));
            end
            @(negedge clk);
            if (r) exp++;
            cyc++;
        end
        checks++;
        if (exp != 16 || done_out !== 1'b1 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: words=%0d done=%b valid=%b required 16 1 0", exp, done_out, valid_out);
        end
        ready_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_data;
        logic        exp_done;
        ready_in = 1'b1;
        load_block(64'h1000);
        for (int w = 0; w < 32; w++) begin
            exp_data = (w < 16) ? 64'h1000 + 64'(w) : 64'h2000 + 64'(w - 16);
            exp_done = (w == 16) ? 1'b1 : 1'b0;
            checks++;
            if (valid_out !== 1'b1 || Data_out !== exp_data || done_out !== exp_done ||
                index_out !== 4'(w % 16)) begin
                errors++;
                $display("FAIL b2b_word%0d: valid=%b data=%h index=%0d done=%b, required 1 %h %0d %b",
                         w, valid_out, Data_out, index_out, done_out, exp_data, w % 16, exp_done);
            end
            if (w == 15) begin
                for (int k = 0; k < 16; k++) res[k] = 64'h2000 + 64'(k);
                load_in = 1'b1;
                #1;
                checks++;
                if (ready_out !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_chain_ready: ready_out=%b required 1", ready_out);
                end
            end
            @(negedge clk);
            load_in = 1'b0;
        end
        checks++;
        if (done_out !== 1'b1 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: done=%b valid=%b required 1 0", done_out, valid_out);
        end
        @(negedge clk);
    endtask

    task automatic test_ignored_load();
        ready_in = 1'b1;
        load_block(64'h1000);
        for (int w = 0; w < 16; w++) begin
            checks++;
            if (valid_out !== 1'b1 || Data_out !== 64'h1000 + 64'(w)) begin
                errors++;
                $display("FAIL ign_word%0d: valid=%b data=%h required 1 %h",
                         w, valid_out, Data_out, 64'h1000 + 64'(w));
            end
            if (w == 5) begin
                for (int k = 0; k < 16; k++) res[k] = 64'hDEAD;
                load_in = 1'b1;
                #1;
                checks++;
                if (ready_out !== 1'b0) begin
                    errors++;
                    $display("FAIL ign_ready: ready_out=%b required 0", ready_out);
                end
            end
            @(negedge clk);
            load_in = 1'b0;
        end
        checks++;
        if (done_out !== 1'b1 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL ign_done: done=%b valid=%b required 1 0", done_out, valid_out);
        end
        @(negedge clk);
    endtask

    task automatic test_stall_last();
        ready_in = 1'b1;
        load_block(64'h4000);
        for (int w = 0; w < 15; w++) @(negedge clk);
        checks++;
        if (Data_out !== 64'h400F || last_out !== 1'b1 || index_out !== 4'd15) begin
            errors++;
            $display("FAIL stall_at_last: data=%h last=%b index=%0d required 400f 1 15",
                     Data_out, last_out, index_out);
        end
        ready_in = 1'b0;
        load_in  = 1'b1;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 16; k++) res[k] = 64'h5000 + 64'(k) + 64'(s * 16'h100);
            #1;
            checks++;
            if (ready_out !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready%0d: ready_out=%b required 0", s, ready_out);
            end
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b1 || Data_out !== 64'h400F || index_out !== 4'd15 ||
                last_out !== 1'b1 || done_out !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b data=%h index=%0d last=%b done=%b, required 1 400f 15 1 0",
                         s, valid_out, Data_out, index_out, last_out, done_out);
            end
        end
        for (int k = 0; k < 16; k++) res[k] = 64'h5000 + 64'(k);
        ready_in = 1'b1;
        #1;
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: ready_out=%b required 1", ready_out);
        end
        @(negedge clk);
        load_in = 1'b0;
        for (int w = 0; w < 16; w++) begin
            checks++;
            if (valid_out !== 1'b1 || Data_out !== 64'h5000 + 64'(w) || index_out !== 4'(w) ||
                done_out !== ((w == 0) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL stall_new_word%0d: valid=%b data=%h index=%0d done=%b, required 1 %h %0d %b",
                         w, valid_out, Data_out, index_out, done_out, 64'h5000 + 64'(w), w,
                         ((w == 0) ? 1'b1 : 1'b0));
            end
            @(negedge clk);
        end
        checks++;
        if (done_out !== 1'b1 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done=%b valid=%b required 1 0", done_out, valid_out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        ready_in = 1'b1;
        load_block(64'h1000);
        for (int w = 0; w < 7; w++) @(negedge clk);
        checks++;
        if (index_out !== 4'd7 || Data_out !== 64'h1007) begin
            errors++;
            $display("FAIL rst_mid_pos: index=%0d data=%h required 7 1007", index_out, Data_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || Data_out !== 64'h0 || index_out !== 4'd0 ||
            done_out !== 1'b0 || last_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: valid=%b data=%h index=%0d done=%b last=%b, required 0 0 0 0 0",
                     valid_out, Data_out, index_out, done_out, last_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ready: ready_out=%b required 1", ready_out);
        end
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || done_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: valid=%b done=%b required 0 0", valid_out, done_out);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        load_in  = 1'b0;
        ready_in = 1'b1;
        for (int k = 0; k < 16; k++) res[k] = 64'h0;

        test_reset();
        test_single_block();
        test_backpressure();
        test_back_to_back();
        test_ignored_load();
        test_stall_last();
        test_reset_midstream();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
